// File: rtl/falling_char_engine.sv
// falling_char_engine: slot manager for falling glyphs, with frame update, key match and a pixel query.
// Optional LIVES_EN: game over after MAX_MISS misses; every 16th hit gives one miss back.
module falling_char_engine #(
  parameter int NUM_SLOTS = 16,
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter int SPEED_W   = 3,
  parameter int CHAR_W    = 9,
  parameter int CHAR_H    = 16,
  parameter int FLOOR_Y   = 480,
  parameter int MAX_MISS  = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           spawn_valid_i,
  output logic                           spawn_ready_o,
  input  logic [7:0]                     spawn_char_i,
  input  logic [X_W-1:0]                 spawn_x_i,
  input  logic [SPEED_W-1:0]             spawn_speed_i,
  input  logic                           frame_tick_i,
  input  logic                           key_valid_i,
  output logic                           key_ready_o,
  input  logic [7:0]                     key_char_i,
  input  logic [X_W-1:0]                 scan_x_i,
  input  logic [Y_W-1:0]                 scan_y_i,
  output logic                           pix_hit_o,
  output logic [7:0]                     pix_char_o,
  output logic [3:0]                     pix_row_o,
  output logic [3:0]                     pix_col_o,
  output logic [15:0]                    score_o,
  output logic [7:0]                     miss_count_o,
  output logic [$clog2(NUM_SLOTS+1)-1:0] active_count_o,
  output logic                           gameover_o
);
  typedef enum logic [2:0] {IDLE, FALL, KSCAN, KCLR, OVER} state_t;
  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(NUM_SLOTS+1);
`ifdef LIVES_EN
  localparam bit LIVES = 1'b1;
`else
  localparam bit LIVES = 1'b0;
`endif
  localparam int MISS_LIM = LIVES ? MAX_MISS : 1;
  state_t               state_q;
  logic [IW-1:0]        idx_q, cand_idx_q, free_idx;
  logic [NUM_SLOTS-1:0] active_q;
  logic [7:0]           char_q [NUM_SLOTS];
  logic [X_W-1:0]       x_q [NUM_SLOTS];
  logic [Y_W-1:0]       y_q [NUM_SLOTS];
  logic [SPEED_W-1:0]   spd_q [NUM_SLOTS];
  logic                 pend_q, cand_v_q, go_q, go_d;
  logic [7:0]           key_q, miss_q, miss_d;
  logic [15:0]          score_q, score_d;
  logic [CW-1:0]        cnt_q;
  logic [Y_W-1:0]       cand_y_q;
  logic [Y_W:0]         y_sum;
  logic                 free_any, last, spawn_fire, fall_miss, hit, cand_upd;
  logic                 pix_hit_q, pix_hit_d;
  logic [7:0]           pix_char_q, pix_char_d;
  logic [3:0]           pix_row_q, pix_row_d, pix_col_q, pix_col_d;
  logic [X_W-1:0]       dx;
  logic [Y_W-1:0]       dy;
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS-1; i >= 0; i--)
      if (!active_q[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    spawn_ready_o = state_q == IDLE && free_any && !go_q;
    key_ready_o   = state_q == IDLE && !frame_tick_i;
    spawn_fire    = spawn_valid_i && spawn_ready_o;
    last          = idx_q == IW'(NUM_SLOTS-1);
    y_sum         = {1'b0, y_q[idx_q]} + (Y_W+1)'(spd_q[idx_q]);
    fall_miss     = state_q == FALL && active_q[idx_q] && y_sum >= (Y_W+1)'(FLOOR_Y);
    cand_upd      = state_q == KSCAN && active_q[idx_q] && char_q[idx_q] == key_q &&
                    (!cand_v_q || y_q[idx_q] > cand_y_q);
    hit           = state_q == KCLR && cand_v_q;
    score_d       = (hit && score_q != 16'hFFFF) ? score_q + 1'b1 : score_q;
    miss_d        = (fall_miss && miss_q != 8'hFF) ? miss_q + 1'b1 : miss_q;
`ifdef LIVES_EN
    if (hit && score_q[3:0] == 4'hF && miss_q != 8'h00) miss_d = miss_q - 1'b1;
`endif
    go_d          = go_q || miss_d >= 8'(MISS_LIM);
  end
  // Reverse scan so the lowest-index matching slot is the one that sticks.
  always_comb begin
    pix_hit_d  = 1'b0;
    pix_char_d = '0;
    pix_row_d  = '0;
    pix_col_d  = '0;
    dx         = '0;
    dy         = '0;
    for (int i = NUM_SLOTS-1; i >= 0; i--) begin
      dx = scan_x_i - x_q[i];
      dy = scan_y_i - y_q[i];
      if (active_q[i] && scan_x_i >= x_q[i] && scan_y_i >= y_q[i] &&
          dx < X_W'(CHAR_W) && dy < Y_W'(CHAR_H)) begin
        pix_hit_d  = 1'b1;
        pix_char_d = char_q[i];
        pix_row_d  = dy[3:0];
        pix_col_d  = dx[3:0];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      active_q   <= '0;
      pend_q     <= 1'b0;
      cand_v_q   <= 1'b0;
      cand_idx_q <= '0;
      cand_y_q   <= '0;
      key_q      <= '0;
      score_q    <= '0;
      miss_q     <= '0;
      cnt_q      <= '0;
      go_q       <= 1'b0;
      pix_hit_q  <= 1'b0;
      pix_char_q <= '0;
      pix_row_q  <= '0;
      pix_col_q  <= '0;
    end else begin
      score_q    <= score_d;
      miss_q     <= miss_d;
      go_q       <= go_d;
      cnt_q      <= spawn_fire ? cnt_q + 1'b1 : (hit || fall_miss) ? cnt_q - 1'b1 : cnt_q;
      pix_hit_q  <= pix_hit_d;
      pix_char_q <= pix_char_d;
      pix_row_q  <= pix_row_d;
      pix_col_q  <= pix_col_d;
      if (spawn_fire) begin
        active_q[free_idx] <= 1'b1;
        char_q[free_idx]   <= spawn_char_i;
        x_q[free_idx]      <= spawn_x_i;
        y_q[free_idx]      <= '0;
        spd_q[free_idx]    <= spawn_speed_i;
      end
      case (state_q)
        IDLE:
          if (frame_tick_i) state_q <= FALL;
          else if (key_valid_i) begin
            key_q    <= key_char_i;
            cand_v_q <= 1'b0;
            state_q  <= KSCAN;
          end
        FALL: begin
          if (fall_miss) active_q[idx_q] <= 1'b0;
          else if (active_q[idx_q]) y_q[idx_q] <= y_sum[Y_W-1:0];
          idx_q <= last ? '0 : idx_q + 1'b1;
          if (last) state_q <= go_d ? OVER : IDLE;
        end
        KSCAN: begin
          if (frame_tick_i) pend_q <= 1'b1;
          if (cand_upd) begin
            cand_v_q   <= 1'b1;
            cand_idx_q <= idx_q;
            cand_y_q   <= y_q[idx_q];
          end
          idx_q <= last ? '0 : idx_q + 1'b1;
          if (last) state_q <= KCLR;
        end
        KCLR: begin
          if (cand_v_q) active_q[cand_idx_q] <= 1'b0;
          pend_q  <= 1'b0;
          state_q <= (pend_q || frame_tick_i) ? FALL : IDLE;
        end
        default: ;
      endcase
    end
  end
  assign pix_hit_o      = pix_hit_q;
  assign pix_char_o     = pix_char_q;
  assign pix_row_o      = pix_row_q;
  assign pix_col_o      = pix_col_q;
  assign score_o        = score_q;
  assign miss_count_o   = miss_q;
  assign active_count_o = cnt_q;
  assign gameover_o     = go_q;
endmodule

// File: tb/tb_falling_char_engine.sv
// tb_falling_char_engine: directed checks of spawn, fall, key clear, query and reset behaviour.
module tb_falling_char_engine;
`ifdef LIVES_EN
  localparam bit LIVES = 1'b1;
`else
  localparam bit LIVES = 1'b0;
`endif
  logic       clk = 1'b0, rst = 1'b1;
  logic       spawn_valid = 1'b0, frame_tick = 1'b0, key_valid = 1'b0;
  logic [7:0] spawn_char = '0, key_char = '0;
  logic [9:0] spawn_x = '0, scan_x = '0, scan_y = '0;
  logic [2:0] spawn_speed = '0;
  logic       spawn_ready, key_ready, pix_hit, gameover;
  logic [7:0] pix_char, miss_count;
  logic [3:0] pix_row, pix_col;
  logic [15:0] score;
  logic [4:0] active_count;
  int checks = 0, errors = 0;

  typedef struct {
    logic [9:0] sx, sy;
    logic       hit;
    logic [7:0] ch;
    logic [3:0] row, col;
  } qvec_t;
  qvec_t qv[8];

  falling_char_engine dut (
    .clk(clk), .rst(rst),
    .spawn_valid_i(spawn_valid), .spawn_ready_o(spawn_ready), .spawn_char_i(spawn_char),
    .spawn_x_i(spawn_x), .spawn_speed_i(spawn_speed), .frame_tick_i(frame_tick),
    .key_valid_i(key_valid), .key_ready_o(key_ready), .key_char_i(key_char),
    .scan_x_i(scan_x), .scan_y_i(scan_y),
    .pix_hit_o(pix_hit), .pix_char_o(pix_char), .pix_row_o(pix_row), .pix_col_o(pix_col),
    .score_o(score), .miss_count_o(miss_count), .active_count_o(active_count),
    .gameover_o(gameover)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!key_ready && n < 200) begin
      tick();
      n++;
    end
    if (!key_ready) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: timeout after %0d cycles", n);
    end
  endtask

  task automatic spawn(input logic [7:0] ch, input logic [9:0] x, input logic [2:0] spd);
    int n = 0;
    while (!spawn_ready && n < 200) begin
      tick();
      n++;
    end
    if (!spawn_ready) begin
      checks++;
      errors++;
      $display("FAIL spawn_wait: spawn_ready never rose for %0h", ch);
    end
    spawn_valid = 1'b1;
    spawn_char = ch;
    spawn_x = x;
    spawn_speed = spd;
    tick();
    spawn_valid = 1'b0;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    repeat (16) tick();
  endtask

  task automatic key(input logic [7:0] ch);
    wait_idle();
    key_valid = 1'b1;
    key_char = ch;
    tick();
    key_valid = 1'b0;
    wait_idle();
  endtask

  task automatic query(input logic [9:0] x, input logic [9:0] y);
    scan_x = x;
    scan_y = y;
    tick();
  endtask

  initial begin
    int n;
    qv[0] = '{10'd100, 10'd12, 1'b1, 8'h41, 4'd0,  4'd0};
    qv[1] = '{10'd109, 10'd12, 1'b0, 8'h00, 4'd0,  4'd0};
    qv[2] = '{10'd108, 10'd27, 1'b1, 8'h41, 4'd15, 4'd8};
    qv[3] = '{10'd108, 10'd28, 1'b0, 8'h00, 4'd0,  4'd0};
    qv[4] = '{10'd99,  10'd12, 1'b0, 8'h00, 4'd0,  4'd0};
    qv[5] = '{10'd100, 10'd11, 1'b0, 8'h00, 4'd0,  4'd0};
    qv[6] = '{10'd104, 10'd20, 1'b1, 8'h41, 4'd8,  4'd4};
    qv[7] = '{10'd0,   10'd0,  1'b0, 8'h00, 4'd0,  4'd0};

    do_reset();
    chk("rst_score", 32'(score), 0);
    chk("rst_miss", 32'(miss_count), 0);
    chk("rst_active", 32'(active_count), 0);
    chk("rst_gameover", 32'(gameover), 0);
    chk("rst_pix_hit", 32'(pix_hit), 0);
    chk("rst_spawn_ready", 32'(spawn_ready), 1);
    chk("rst_key_ready", 32'(key_ready), 1);

    // 'A' at x=100 falling 4 rows per frame reaches y=12 after three frames
    spawn(8'h41, 10'd100, 3'd4);
    chk("spawn_active", 32'(active_count), 1);
    repeat (3) frame();
    for (int i = 0; i < 8; i++) begin
      query(qv[i].sx, qv[i].sy);
      chk($sformatf("q%0d_hit", i), 32'(pix_hit), 32'(qv[i].hit));
      chk($sformatf("q%0d_char", i), 32'(pix_char), 32'(qv[i].ch));
      chk($sformatf("q%0d_row", i), 32'(pix_row), 32'(qv[i].row));
      chk($sformatf("q%0d_col", i), 32'(pix_col), 32'(qv[i].col));
    end

    // two 'B's: slot0 y=6, slot1 y=15 -> slot1 cleared
    do_reset();
    spawn(8'h42, 10'd0, 3'd1);
    frame();
    spawn(8'h42, 10'd200, 3'd3);
    repeat (5) frame();
    key(8'h42);
    chk("b_score", 32'(score), 1);
    chk("b_active", 32'(active_count), 1);
    query(10'd200, 10'd15);
    chk("b_cleared_gone", 32'(pix_hit), 0);
    query(10'd0, 10'd6);
    chk("b_other_hit", 32'(pix_hit), 1);
    chk("b_other_char", 32'(pix_char), 32'h42);

    // equal y tie -> lowest index cleared
    do_reset();
    spawn(8'h43, 10'd0, 3'd2);
    spawn(8'h43, 10'd50, 3'd2);
    frame();
    key(8'h43);
    chk("tie_score", 32'(score), 1);
    query(10'd0, 10'd2);
    chk("tie_slot0_gone", 32'(pix_hit), 0);
    query(10'd50, 10'd2);
    chk("tie_slot1_kept", 32'(pix_hit), 1);

    // fill every slot, then a key that matches nothing
    do_reset();
    for (int i = 0; i < 16; i++) spawn(8'(8'h61 + i), 10'(i * 30), 3'd0);
    chk("full_ready", 32'(spawn_ready), 0);
    chk("full_active", 32'(active_count), 16);
    key(8'h23);
    chk("nomatch_score", 32'(score), 0);
    chk("nomatch_active", 32'(active_count), 16);
    chk("nomatch_ready", 32'(spawn_ready), 0);

    // speed 7: y=476 after 68 frames, missed on frame 69
    do_reset();
    spawn(8'h4D, 10'd0, 3'd7);
    spawn(8'h5A, 10'd300, 3'd0);
    repeat (68) frame();
    chk("pre_miss", 32'(miss_count), 0);
    chk("pre_active", 32'(active_count), 2);
    chk("pre_gameover", 32'(gameover), 0);
    frame();
    chk("miss_count", 32'(miss_count), 1);
    chk("miss_active", 32'(active_count), 1);
    chk("miss_gameover", 32'(gameover), LIVES ? 0 : 1);
    chk("over_spawn_ready", 32'(spawn_ready), LIVES ? 1 : 0);
    chk("over_key_ready", 32'(key_ready), LIVES ? 1 : 0);
    query(10'd300, 10'd0);
    chk("over_query_hit", 32'(pix_hit), 1);
    chk("over_query_char", 32'(pix_char), 32'h5A);

    // frame_tick beats a simultaneous key; key accepted after the 16-cycle sweep
    do_reset();
    spawn(8'h4B, 10'd0, 3'd1);
    frame_tick = 1'b1;
    key_valid = 1'b1;
    key_char = 8'h4B;
    #1;
    chk("prio_key_ready", 32'(key_ready), 0);
    tick();
    frame_tick = 1'b0;
    n = 0;
    while (!key_ready && n < 100) begin
      tick();
      n++;
    end
    chk("prio_fall_len", 32'(n), 16);
    tick();
    key_valid = 1'b0;
    chk("prio_kscan_busy", 32'(key_ready), 0);
    wait_idle();
    chk("prio_score", 32'(score), 1);
    chk("prio_active", 32'(active_count), 0);

    // reset in the middle of a key scan
    do_reset();
    for (int i = 0; i < 5; i++) spawn(8'(8'h61 + i), 10'(i * 30), 3'd0);
    scan_x = 10'd0;
    scan_y = 10'd0;
    key_valid = 1'b1;
    key_char = 8'h63;
    tick();
    key_valid = 1'b0;
    repeat (5) tick();
    chk("mid_pix_hit", 32'(pix_hit), 1);
    chk("mid_busy", 32'(key_ready), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_active", 32'(active_count), 0);
    chk("mid_rst_score", 32'(score), 0);
    chk("mid_rst_spawn_ready", 32'(spawn_ready), 1);
    chk("mid_rst_key_ready", 32'(key_ready), 1);
    chk("mid_rst_pix_hit", 32'(pix_hit), 0);
    repeat (20) tick();
    chk("mid_rst_score_later", 32'(score), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
